// File: rtl/pipe_world_model_if.sv
// Command/sensor/status bundle between the robot controller (master) and the pipe world model (slave).
// Pure wiring: no latency, no backpressure; the controller issues at most one command per cycle.
interface pipe_world_model_if #(
    parameter int XW = 2,
    parameter int YW = 2
);
    logic          front;
    logic          turn;
    logic          remove;
    logic          head;
    logic          left;
    logic          under;
    logic          barrier;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic [1:0]    dir;
    logic [7:0]    trash_left;
    logic [15:0]   step_count;
    logic          collision;
    logic          cmd_error;
    logic          done;

    modport master (
        output front, turn, remove,
        input  head, left, under, barrier,
        input  pos_x, pos_y, dir, trash_left, step_count,
        input  collision, cmd_error, done
    );

    modport slave (
        input  front, turn, remove,
        output head, left, under, barrier,
        output pos_x, pos_y, dir, trash_left, step_count,
        output collision, cmd_error, done
    );
endinterface

// File: rtl/pipe_world_model.sv
// Pipe world model: grid plant driving robot sensors from registered pose and trash state.
// Latency: 1 cycle command->sensor; no backpressure, one command is consumed every cycle.
module pipe_world_model #(
    parameter int                         GRID_W        = 4,
    parameter int                         GRID_H        = 4,
    parameter logic [GRID_W*GRID_H-1:0]   WALL_MAP      = '0,
    parameter logic [GRID_W*GRID_H-1:0]   TRASH_MAP     = '0,
    parameter int                         START_X       = 0,
    parameter int                         START_Y       = 0,
    parameter int                         START_DIR     = 1,
    parameter int                         EXIT_X        = 3,
    parameter int                         EXIT_Y        = 3,
    parameter int                         REMOVE_CYCLES = 3
) (
    input  logic               clock,
    input  logic               reset,
    pipe_world_model_if.slave  bus
);
    localparam int N  = GRID_W * GRID_H;
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int IW = $clog2(N);

    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);
    localparam logic [XW-1:0] X_EXIT  = XW'(EXIT_X);
    localparam logic [YW-1:0] Y_EXIT  = YW'(EXIT_Y);
    localparam logic [1:0]    D_START = 2'(START_DIR);
    localparam logic          DONE_INIT = (START_X == EXIT_X) && (START_Y == EXIT_Y);

    // Trash sitting on a wall can never be reached, so it is dropped at reset.
    localparam logic [N-1:0]  TRASH_INIT = TRASH_MAP & ~WALL_MAP;
    localparam logic [7:0]    TRASH_CNT  = 8'($countones(TRASH_INIT));
    localparam logic [3:0]    RM_LAST    = 4'(REMOVE_CYCLES - 1);

    typedef struct packed {
        logic          off;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } cell_t;

    // Underflow at the low edges is caught by the ==0 test before the wrapped coordinate is used.
    function automatic cell_t neighbor(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                       input logic [1:0] d);
        cell_t c;
        c.off = 1'b0;
        c.x   = x;
        c.y   = y;
        case (d)
            2'd0:    begin c.off = (y == '0);    c.y = y - YW'(1); end
            2'd1:    begin c.off = (x == X_MAX); c.x = x + XW'(1); end
            2'd2:    begin c.off = (y == Y_MAX); c.y = y + YW'(1); end
            default: begin c.off = (x == '0);    c.x = x - XW'(1); end
        endcase
        return c;
    endfunction

    function automatic logic [IW-1:0] cell_index(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return IW'(y) * IW'(GRID_W) + IW'(x);
    endfunction

    logic [XW-1:0] pos_x_q;
    logic [YW-1:0] pos_y_q;
    logic [1:0]    dir_q;
    logic [N-1:0]  trash_q;
    logic [7:0]    trash_left_q;
    logic [15:0]   step_q;
    logic [3:0]    rm_cnt_q;
    logic          collision_q;
    logic          cmd_error_q;
    logic          done_q;

    cell_t         ahead;
    cell_t         side;
    logic [IW-1:0] ahead_idx;
    logic [IW-1:0] side_idx;
    logic          ahead_blk;
    logic          ahead_trash;
    logic          side_blk;
    logic          at_exit;
    logic          ahead_is_exit;
    logic [15:0]   step_nxt;

    always_comb begin
        ahead         = neighbor(pos_x_q, pos_y_q, dir_q);
        side          = neighbor(pos_x_q, pos_y_q, dir_q - 2'd1);
        ahead_idx     = cell_index(ahead.x, ahead.y);
        side_idx      = cell_index(side.x, side.y);
        ahead_blk     = ahead.off | WALL_MAP[ahead_idx];
        ahead_trash   = ~ahead.off & trash_q[ahead_idx];
        side_blk      = side.off | WALL_MAP[side_idx];
        at_exit       = (pos_x_q == X_EXIT) && (pos_y_q == Y_EXIT);
        ahead_is_exit = (ahead.x == X_EXIT) && (ahead.y == Y_EXIT);
        step_nxt      = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pos_x_q      <= X_START;
            pos_y_q      <= Y_START;
            dir_q        <= D_START;
            trash_q      <= TRASH_INIT;
            trash_left_q <= TRASH_CNT;
            step_q       <= '0;
            rm_cnt_q     <= '0;
            collision_q  <= 1'b0;
            cmd_error_q  <= 1'b0;
            done_q       <= DONE_INIT;
        end else if (!done_q) begin
            case ({bus.front, bus.turn, bus.remove})
                3'b000: rm_cnt_q <= '0;
                3'b100: begin
                    rm_cnt_q <= '0;
                    step_q   <= step_nxt;
                    if (ahead_blk || ahead_trash) begin
                        collision_q <= 1'b1;
                    end else begin
                        pos_x_q <= ahead.x;
                        pos_y_q <= ahead.y;
                        if (ahead_is_exit) done_q <= 1'b1;
                    end
                end
                3'b010: begin
                    rm_cnt_q <= '0;
                    step_q   <= step_nxt;
                    dir_q    <= dir_q + 2'd1;
                end
                3'b001: begin
                    step_q <= step_nxt;
                    if (!ahead_trash) begin
                        cmd_error_q <= 1'b1;
                        rm_cnt_q    <= '0;
                    end else if (rm_cnt_q == RM_LAST) begin
                        trash_q[ahead_idx] <= 1'b0;
                        rm_cnt_q           <= '0;
                        if (trash_left_q != 8'd0) trash_left_q <= trash_left_q - 8'd1;
                    end else begin
                        rm_cnt_q <= rm_cnt_q + 4'd1;
                    end
                end
                default: begin
                    cmd_error_q <= 1'b1;
                    rm_cnt_q    <= '0;
                end
            endcase
        end
    end

    assign bus.head       = ahead_blk;
    assign bus.left       = side_blk;
    assign bus.under      = at_exit;
    assign bus.barrier    = ahead_trash;
    assign bus.pos_x      = pos_x_q;
    assign bus.pos_y      = pos_y_q;
    assign bus.dir        = dir_q;
    assign bus.trash_left = trash_left_q;
    assign bus.step_count = step_q;
    assign bus.collision  = collision_q;
    assign bus.cmd_error  = cmd_error_q;
    assign bus.done       = done_q;
endmodule
